// File: rtl/lpc_record_packer.sv
// Buffers decoded LPC cycles as 72-bit records in a small FIFO and serializes each one
// as a 10-byte frame (sync, type/size, address, data) over a valid/ready byte stream.
module lpc_record_packer #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'h5A
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  in_cyctype_dir,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_data_size,
  input  logic        in_clock_enable,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_fifo_count,
  output logic        out_overflow,
  output logic [7:0]  out_drop_count
);

  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_CNT = 4'(DEPTH);

  typedef enum logic {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [71:0]      rec_q, rec_d;
  logic [71:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]       count_q, count_d;
  logic             overflow_q;
  logic [7:0]       drop_q;
  logic             pop, push_ok, drop;
  logic [71:0]      rec_in;

  assign rec_in = {in_cyctype_dir, in_data_size, in_addr, in_data};

  // A pop on the same edge frees a slot, so a full FIFO can still take the write.
  assign push_ok = in_clock_enable && ((count_q < DEPTH_CNT) || pop);
  assign drop    = in_clock_enable && !push_ok;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rec_d     = rec_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    case (state_q)
      StIdle: begin
        if (count_q != 4'd0) begin
          pop     = 1'b1;
          rec_d   = mem_q[rd_ptr_q];
          idx_d   = 4'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        out_valid = 1'b1;
        case (idx_q)
          4'd0:    out_byte = SYNC_BYTE;
          4'd1:    out_byte = rec_q[71:64];
          4'd2:    out_byte = rec_q[63:56];
          4'd3:    out_byte = rec_q[55:48];
          4'd4:    out_byte = rec_q[47:40];
          4'd5:    out_byte = rec_q[39:32];
          4'd6:    out_byte = rec_q[31:24];
          4'd7:    out_byte = rec_q[23:16];
          4'd8:    out_byte = rec_q[15:8];
          4'd9:    out_byte = rec_q[7:0];
          default: out_byte = 8'h00;
        endcase
        if (out_ready) begin
          if (idx_q == 4'd9) begin
            idx_d = 4'd0;
            // Chain straight into the next record to avoid an idle bubble.
            if (count_q != 4'd0) begin
              pop   = 1'b1;
              rec_d = mem_q[rd_ptr_q];
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      rec_q      <= 72'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rec_q   <= rec_d;
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge lpc_clock) begin
    if (push_ok && !lpc_reset) mem_q[wr_ptr_q] <= rec_in;
  end

  assign out_fifo_count = count_q;
  assign out_overflow   = overflow_q;
  assign out_drop_count = drop_q;

endmodule

// File: tb/tb_lpc_record_packer.sv
// Scoreboarded bench for lpc_record_packer: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares every transferred byte.
module tb_lpc_record_packer;

  logic        clk = 1'b0;
  logic        lpc_reset;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_data_size;
  logic        in_clock_enable;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_fifo_count;
  logic        out_overflow;
  logic [7:0]  out_drop_count;

  lpc_record_packer #(.DEPTH(8), .SYNC_BYTE(8'h5A)) dut (
    .lpc_clock       (clk),
    .lpc_reset       (lpc_reset),
    .in_cyctype_dir  (in_cyctype_dir),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .in_data_size    (in_data_size),
    .in_clock_enable (in_clock_enable),
    .out_byte        (out_byte),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_fifo_count  (out_fifo_count),
    .out_overflow    (out_overflow),
    .out_drop_count  (out_drop_count)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         nbytes = 0;
  bit         mon_en = 1'b0;
  logic [7:0] sb [$];
  logic [7:0] mon_exp;

  // Hand-computed frame for cyctype 0, size 1, addr 00007fe5, data 0000006c.
  logic [7:0] exp1 [10] = '{8'h5A, 8'h01, 8'h00, 8'h00, 8'h7F, 8'hE5,
                            8'h00, 8'h00, 8'h00, 8'h6C};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic [3:0] ct, input logic [3:0] sz,
                                     input logic [31:0] a, input logic [31:0] d);
    return {ct, sz, a, d};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [71:0] r, input int k);
    if (k == 0) return 8'h5A;
    return r[71 - 8*(k-1) -: 8];
  endfunction

  task automatic expect_rec(input logic [71:0] r);
    for (int k = 0; k < 10; k++) sb.push_back(frame_byte(r, k));
  endtask

  // Called at posedge+1; strobes on the next edge and returns at posedge+1.
  task automatic strobe(input logic [71:0] r, input bit accepted);
    {in_cyctype_dir, in_data_size, in_addr, in_data} = r;
    in_clock_enable = 1'b1;
    if (accepted) expect_rec(r);
    @(posedge clk); #1;
    in_clock_enable = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b0 && out_fifo_count == 4'd0 && sb.size() == 0) done = 1'b1;
    end
    check({name, "_drained"}, {31'd0, done}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (mon_en && !lpc_reset) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        nbytes++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %h expected none", out_byte);
        end else begin
          mon_exp = sb.pop_front();
          check("byte", {24'd0, out_byte}, {24'd0, mon_exp});
        end
      end else if (out_valid === 1'b0) begin
        check("idle_byte_zero", {24'd0, out_byte}, 32'd0);
      end
    end
  end

  initial begin
    logic [71:0] r1;
    r1 = mk(4'h0, 4'h1, 32'h00007fe5, 32'h0000006c);
    lpc_reset = 1'b1;
    in_clock_enable = 1'b0;
    {in_cyctype_dir, in_data_size, in_addr, in_data} = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lpc_reset = 1'b0;
    mon_en = 1'b1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_byte", {24'd0, out_byte}, 32'd0);
    check("rst_count", {28'd0, out_fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, out_overflow}, 32'd0);
    check("rst_drops", {24'd0, out_drop_count}, 32'd0);

    // Single record: valid rises two edges after the strobe, 10 consecutive bytes.
    for (int k = 0; k < 10; k++) sb.push_back(exp1[k]);
    strobe(r1, 1'b0);
    check("single_valid_e0", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("single_valid_run", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    check("single_valid_end", {31'd0, out_valid}, 32'd0);
    check("single_sb_empty", sb.size(), 32'd0);

    // Backpressure while index 4 (7F) is presented.
    for (int k = 0; k < 10; k++) sb.push_back(exp1[k]);
    strobe(r1, 1'b0);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_byte", {24'd0, out_byte}, 32'h7F);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    wait_drained("stall");

    // Overflow: 10 strobes with the consumer stalled; the 10th is dropped.
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++)
      strobe(mk(4'(i), 4'h4, 32'h1000 + 32'(i), 32'hA0 + 32'(i)), i <= 9);
    check("ovf_count", {28'd0, out_fifo_count}, 32'd8);
    check("ovf_flag", {31'd0, out_overflow}, 32'd1);
    check("ovf_drops", {24'd0, out_drop_count}, 32'd1);
    nbytes = 0;
    out_ready = 1'b1;
    wait_drained("ovf");
    check("ovf_nbytes", nbytes, 32'd90);
    check("ovf_sticky", {31'd0, out_overflow}, 32'd1);

    // Back-to-back records: 20 valid bytes with no gap.
    @(posedge clk); #1;
    lpc_reset = 1'b1;
    @(posedge clk); #1;
    lpc_reset = 1'b0;
    check("rst2_overflow", {31'd0, out_overflow}, 32'd0);
    strobe(mk(4'h2, 4'h1, 32'hDEADBEEF, 32'h01234567), 1'b1);
    strobe(mk(4'h3, 4'h2, 32'hCAFEF00D, 32'h89ABCDEF), 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("b2b_valid_run", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    check("b2b_valid_end", {31'd0, out_valid}, 32'd0);
    wait_drained("b2b");

    // Full FIFO with a strobe on the edge where index 9 transfers.
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) strobe(mk(4'h5, 4'h1, 32'h2000 + 32'(i), 32'(i)), 1'b1);
    check("full_count", {28'd0, out_fifo_count}, 32'd8);
    out_ready = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    strobe(mk(4'h6, 4'h1, 32'h3000, 32'h55AA55AA), 1'b1);
    check("pushpop_count", {28'd0, out_fifo_count}, 32'd8);
    check("pushpop_overflow", {31'd0, out_overflow}, 32'd0);
    check("pushpop_drops", {24'd0, out_drop_count}, 32'd0);
    wait_drained("pushpop");

    // Reset at index 3 abandons the frame; a strobe on the reset edge is ignored.
    strobe(r1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    lpc_reset = 1'b1;
    {in_cyctype_dir, in_data_size, in_addr, in_data} = mk(4'hF, 4'hF, 32'hFFFF, 32'hFFFF);
    in_clock_enable = 1'b1;
    @(posedge clk); #1;
    lpc_reset = 1'b0;
    in_clock_enable = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_count", {28'd0, out_fifo_count}, 32'd0);
    check("midrst_left", sb.size(), 32'd7);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_quiet", {31'd0, out_valid}, 32'd0);
    strobe(mk(4'h1, 4'h4, 32'h000000AB, 32'h12345678), 1'b1);
    wait_drained("midrst");

    check("final_sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
